// File: rtl/tv80_bus_bridge.sv
// Memory/IO bridge behind the TV80 core: decodes CPU strobes into ROM, RAM and IO
// accesses, stalls the CPU on slow ROM reads and muxes read data back onto di.
module tv80_bus_bridge #(
  parameter logic [15:0] ROM_END   = 16'hDFFF,
  parameter logic [15:0] RAM_BASE  = 16'hE000,
  parameter logic [15:0] RAM_END   = 16'hEFFF,
  parameter int          RAM_AW    = 12,
  parameter logic [7:0]  IM_VECTOR = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       A,
  input  logic [7:0]        dout,
  input  logic              m1_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              rfsh_n,
  output logic [7:0]        di,
  output logic              wait_n,
  output logic              rom_req,
  output logic [15:0]       rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_q,
  output logic [7:0]        io_addr,
  output logic              io_wr,
  output logic              io_rd,
  output logic [7:0]        io_dout,
  input  logic [7:0]        io_din
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_romBuf;
  logic        r_prevRamWr;
  logic        r_prevIoWr;
  logic        r_prevIoRd;

  logic        w_romRegion;
  logic        w_ramSel;
  logic        w_romRd;
  logic        w_ioCyc;
  logic        w_inta;
  logic        w_ramWr;
  logic        w_ioWr;
  logic        w_ioRd;
  logic [15:0] w_ramOffset;

  // Refresh cycles drive mreq_n low with a refresh address, so they are kept out of every access
  assign w_romRegion = (A <= ROM_END);
  assign w_ramSel    = (A >= RAM_BASE) && (A <= RAM_END);
  assign w_romRd     = !mreq_n && !rd_n && rfsh_n && w_romRegion;
  assign w_ioCyc     = !iorq_n && m1_n;
  assign w_inta      = !iorq_n && !m1_n;
  assign w_ramWr     = !mreq_n && !wr_n && rfsh_n && w_ramSel;
  assign w_ioWr      = w_ioCyc && !wr_n;
  assign w_ioRd      = w_ioCyc && !rd_n;
  assign w_ramOffset = A - RAM_BASE;

  assign ram_addr = w_ramOffset[RAM_AW-1:0];
  assign ram_din  = dout;
  assign io_addr  = A[7:0];
  assign io_dout  = dout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      rom_req     <= 1'b0;
      rom_addr    <= 16'h0000;
      r_romBuf    <= 8'hFF;
      r_prevRamWr <= 1'b0;
      r_prevIoWr  <= 1'b0;
      r_prevIoRd  <= 1'b0;
    end else begin
      r_prevRamWr <= w_ramWr;
      r_prevIoWr  <= w_ioWr;
      r_prevIoRd  <= w_ioRd;
      case (r_state)
        ST_IDLE: begin
          if (w_romRd) begin
            rom_addr <= A;
            rom_req  <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rom_ack) begin
            r_romBuf <= rom_data;
            rom_req  <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        // Wait for the CPU to release the strobes so one bus cycle issues one request
        ST_DONE: begin
          if (rd_n && mreq_n) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes pulse only on the first sampled cycle of each qualifying bus cycle
  assign ram_we = reset_n && w_ramWr && !r_prevRamWr;
  assign io_wr  = reset_n && w_ioWr && !r_prevIoWr;
  assign io_rd  = reset_n && w_ioRd && !r_prevIoRd;

  assign wait_n = !reset_n || !(w_romRd && (r_state != ST_DONE));

  always_comb begin
    di = 8'hFF;
    if (reset_n) begin
      if (w_inta) begin
        di = IM_VECTOR;
      end else if (w_ioCyc) begin
        di = io_din;
      end else if (w_romRegion) begin
        di = r_romBuf;
      end else if (w_ramSel) begin
        di = ram_q;
      end
    end
  end

endmodule

// File: doc/tv80_bus_bridge.md
# tv80_bus_bridge

Downstream memory/IO bridge for the negative-edge TV80 wrapper. Decodes the CPU's `mreq_n`/`iorq_n`/`rd_n`/`wr_n` strobes into ROM, RAM and IO accesses. Runs a request/acknowledge handshake to slow external ROM and holds `wait_n` low until ROM data arrives. Returns the selected read data on `di`, including the interrupt-acknowledge vector.

## Interface
Parameters:
- `ROM_END`, 16'hDFFF, last ROM address; ROM region is 0x0000..ROM_END
- `RAM_BASE`, 16'hE000, first RAM address
- `RAM_END`, 16'hEFFF, last RAM address
- `RAM_AW`, 12, RAM address width
- `IM_VECTOR`, 8'hFF, data returned on interrupt acknowledge

Ports:
- `clk`  in  1  system clock; same clock as the CPU
- `reset_n`  in  1  synchronous, active-low reset
- `A`  in  16  CPU address
- `dout`  in  8  CPU write data
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n`  in  1 each  CPU strobes; change on negedge
- `di`  out  8  read data to CPU (combinational mux)
- `wait_n`  out  1  CPU wait (combinational)
- `rom_req`  out  1  ROM request level
- `rom_addr`  out  16  ROM address, registered at request
- `rom_ack`  in  1  one-cycle pulse; `rom_data` valid in that cycle
- `rom_data`  in  8  ROM data
- `ram_addr`  out  RAM_AW  A − RAM_BASE, combinational
- `ram_we`  out  1  one-cycle RAM write pulse
- `ram_din`  out  8  = `dout`
- `ram_q`  in  8  synchronous RAM read data, 1-cycle latency
- `io_addr`  out  8  = A[7:0]
- `io_wr`, `io_rd`  out  1  one-cycle IO strobes
- `io_dout`  out  8  = `dout`
- `io_din`  in  8  IO read data, sampled combinationally

## Operation
- Decode, sampled on posedge:
  - `rom_rd` = !mreq_n && !rd_n && A<=ROM_END
  - `ram_sel` = RAM_BASE<=A<=RAM_END
  - `io_cyc` = !iorq_n && m1_n
  - `inta` = !iorq_n && !m1_n
- Refresh (`!rfsh_n`) never triggers an access. ROM writes and unmapped writes are dropped.
- FSM states:
  - IDLE: on `rom_rd`, register `rom_addr`<=A and `rom_req`<=1; go to REQ.
  - REQ: on `rom_ack`, latch `rom_data` into `rom_buf`, `rom_req`<=0; go to DONE.
  - DONE: when `rd_n` and `mreq_n` are both high, go to IDLE.
- `wait_n` = 0 when `rom_rd` && state!=DONE; otherwise 1. Forced to 1 during reset.
- `di` priority:
  1. `inta` → IM_VECTOR
  2. `io_cyc` → `io_din`
  3. ROM region → `rom_buf`
  4. `ram_sel` → `ram_q`
  5. else 8'hFF
- Edge strobes: `prev` registers hold `wr_n`/`rd_n` gated by region.
  - `ram_we` = 1 for exactly the first cycle `!mreq_n && !wr_n && ram_sel` is sampled.
  - `io_wr` = 1 on the first cycle of `io_cyc && !wr_n`.
  - `io_rd` = 1 on the first cycle of `io_cyc && !rd_n`.
  - Never more than one pulse per bus cycle.
- `inta` produces no `io_rd`.

## Timing
- All registers update on posedge `clk`; strobes from the CPU are stable at posedge.
- Reset values: state IDLE, `rom_req` 0, `rom_addr` 0, `rom_buf` 8'hFF, `ram_we`/`io_wr`/`io_rd` 0, `wait_n` 1, `di` 8'hFF.
- ROM read latency: `rom_req` rises 1 cycle after `rom_rd` is first sampled.
  - `wait_n` is low from that first sample until the cycle after `rom_ack`.
  - `rom_ack` in the same cycle `rom_req` rises is valid: minimum 1 wait cycle.
- `rom_ack` while in IDLE or DONE is ignored. `rom_req` stays high indefinitely without an ack (no timeout).
- RAM reads need no wait: `ram_addr` is valid from the strobe, and `ram_q` is valid by T3.
- Back-to-back ROM reads: DONE must observe the strobes high for ≥1 cycle before a new request. An address change without strobe release does not restart the FSM.
- Reset asserted in REQ: return to IDLE and drop `rom_req` next cycle; a later `rom_ack` is ignored.
- An M1 opcode fetch from ROM behaves identically to a ROM read.

## Test plan
- Opcode fetch at 0x0100, `rom_ack` 3 cycles after `rom_req` with data 0x3E:
  - `rom_addr`=0x0100
  - `wait_n` low 4 cycles
  - `di`=0x3E while `wait_n` high
- Write 0x5A to 0xE123, then read it back:
  - one `ram_we` pulse, `ram_addr`=0x123
  - read returns 0x5A with `wait_n` never low
- `OUT (0x40),A` with A=0x77: exactly one `io_wr` pulse, `io_addr`=0x40, `io_dout`=0x77.
- `IN A,(0x41)` with `io_din`=0xC3: one `io_rd` pulse, `di`=0xC3.
- Interrupt acknowledge (`m1_n`=0, `iorq_n`=0): `di`=0xFF (IM_VECTOR), no `io_rd`.
- Read at 0xF000: `di`=0xFF, no wait.
- Write at 0x1000: no `ram_we`, no `rom_req`.
- Reset asserted during REQ, then `rom_ack` pulses: `rom_req`=0 and state IDLE after reset; the late ack leaves `rom_buf`=0xFF.
